// File: rtl/branch_trace_driver.sv
// Branch trace driver: replays a stored (index, outcome) trace into a
// predictor, scores each prediction and tracks the longest miss streak.
module branch_trace_driver #(
    parameter int K     = 4,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int HOLD  = 2,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [K-1:0]  load_index,
    input  logic          load_outcome,
    input  logic          start,
    input  logic [AW:0]   length,
    input  logic          prediction,
    output logic [K-1:0]  index,
    output logic          branch_outcome,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] hit_count,
    output logic [CW-1:0] miss_count,
    output logic [CW-1:0] max_miss_streak
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PRESENT, DONE} state_t;

    state_t        state_q, state_d;
    logic [K:0]    mem_q [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW:0]   effLen_q, effLen_d;
    logic [K-1:0]  index_q, index_d;
    logic          outcome_q, outcome_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] hit_q, hit_d;
    logic [CW-1:0] miss_q, miss_d;
    logic [CW-1:0] streak_q, streak_d;
    logic [CW-1:0] maxStreak_q, maxStreak_d;

    logic [AW:0]   reqLen;
    logic [CW-1:0] streakInc;
    logic          lastHold;
    logic          lastEntry;
    logic [K:0]    firstEntry;
    logic [K:0]    nextEntry;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    // Trace memory: loadable only while idle, never cleared by reset.
    always_ff @(posedge clk) begin
        if (load_en && state_q == IDLE) begin
            mem_q[load_addr] <= {load_index, load_outcome};
        end
    end

    // Next-state logic: playback sequencing, entry presentation and scoring.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        effLen_d    = effLen_q;
        index_d     = index_q;
        outcome_d   = outcome_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        hit_d       = hit_q;
        miss_d      = miss_q;
        streak_d    = streak_q;
        maxStreak_d = maxStreak_q;

        reqLen     = (length > DEPTH_L) ? DEPTH_L : length;
        streakInc  = satInc(streak_q);
        lastHold   = (hold_q == HW'(HOLD - 1));
        lastEntry  = ({1'b0, ptr_q} == effLen_q - (AW+1)'(1));
        firstEntry = mem_q[0];
        nextEntry  = mem_q[ptr_q + AW'(1)];

        case (state_q)
            IDLE: begin
                if (start) begin
                    hit_d       = '0;
                    miss_d      = '0;
                    streak_d    = '0;
                    maxStreak_d = '0;
                    effLen_d    = reqLen;
                    ptr_d       = '0;
                    hold_d      = '0;
                    if (reqLen == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d              = PRESENT;
                        valid_d              = 1'b1;
                        busy_d               = 1'b1;
                        {index_d, outcome_d} = firstEntry;
                    end
                end
            end
            PRESENT: begin
                if (hold_q == '0) begin
                    if (prediction == outcome_q) begin
                        hit_d    = satInc(hit_q);
                        streak_d = '0;
                    end else begin
                        miss_d   = satInc(miss_q);
                        streak_d = streakInc;
                        if (streakInc > maxStreak_q) begin
                            maxStreak_d = streakInc;
                        end
                    end
                end
                if (lastHold) begin
                    hold_d = '0;
                    if (lastEntry) begin
                        state_d   = DONE;
                        valid_d   = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        index_d   = '0;
                        outcome_d = 1'b0;
                    end else begin
                        ptr_d                = ptr_q + AW'(1);
                        {index_d, outcome_d} = nextEntry;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts playback and clears statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            effLen_q    <= '0;
            index_q     <= '0;
            outcome_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
            streak_q    <= '0;
            maxStreak_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            effLen_q    <= effLen_d;
            index_q     <= index_d;
            outcome_q   <= outcome_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            streak_q    <= streak_d;
            maxStreak_q <= maxStreak_d;
        end
    end

    assign index           = index_q;
    assign branch_outcome  = outcome_q;
    assign valid           = valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign hit_count       = hit_q;
    assign miss_count      = miss_q;
    assign max_miss_streak = maxStreak_q;

endmodule

// File: tb/tb_branch_trace_driver.sv
// Testbench for branch_trace_driver: two instances (CW=8 and CW=2) share all
// inputs; a trace-level model predicts presentation timing and statistics.
module tb_branch_trace_driver;

    localparam int K     = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int HOLD  = 2;
    localparam int CW    = 8;
    localparam int CW2   = 2;

    logic          clk;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [K-1:0]  load_index;
    logic          load_outcome;
    logic          start;
    logic [AW:0]   length;
    logic          prediction;

    logic [K-1:0]   index, index2;
    logic           branch_outcome, outcome2;
    logic           valid, valid2, busy, busy2, done, done2;
    logic [CW-1:0]  hit_count, miss_count, max_miss_streak;
    logic [CW2-1:0] hit2, miss2, max2;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference trace contents and prediction source
    logic [K-1:0] mdlIdx [DEPTH];
    logic         mdlOut [DEPTH];
    logic         predTable [2**K];
    int           predMode;
    logic         predConst;

    assign prediction = (predMode == 2) ? predTable[index] : predConst;

    branch_trace_driver #(.K(K), .DEPTH(DEPTH), .AW(AW), .HOLD(HOLD), .CW(CW)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_index(load_index), .load_outcome(load_outcome), .start(start),
        .length(length), .prediction(prediction), .index(index),
        .branch_outcome(branch_outcome), .valid(valid), .busy(busy), .done(done),
        .hit_count(hit_count), .miss_count(miss_count), .max_miss_streak(max_miss_streak)
    );

    branch_trace_driver #(.K(K), .DEPTH(DEPTH), .AW(AW), .HOLD(HOLD), .CW(CW2)) dutSat (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_index(load_index), .load_outcome(load_outcome), .start(start),
        .length(length), .prediction(prediction), .index(index2),
        .branch_outcome(outcome2), .valid(valid2), .busy(busy2), .done(done2),
        .hit_count(hit2), .miss_count(miss2), .max_miss_streak(max2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    // Trace-level scoring of the first n entries
    task automatic computeModel(input int n, output int hits, output int misses, output int longest);
        int run;
        logic p;
        hits = 0; misses = 0; longest = 0; run = 0;
        for (int i = 0; i < n; i++) begin
            p = (predMode == 2) ? predTable[mdlIdx[i]] : predConst;
            if (p == mdlOut[i]) begin
                hits++;
                run = 0;
            end else begin
                misses++;
                run++;
                if (run > longest) longest = run;
            end
        end
    endtask

    task automatic loadEntry(input int addr, input logic [K-1:0] idx, input logic outc);
        load_en      = 1'b1;
        load_addr    = AW'(addr);
        load_index   = idx;
        load_outcome = outc;
        @(posedge clk); #1;
        load_en      = 1'b0;
        mdlIdx[addr] = idx;
        mdlOut[addr] = outc;
    endtask

    task automatic randomizeTable();
        for (int i = 0; i < 2**K; i++) predTable[i] = 1'($urandom);
    endtask

    // Starts a playback, checks every presented cycle and the final statistics
    task automatic play_and_score(input string name, input int len, input bit disturb);
        int effLen, lastCycle, doneSeen, entry, hits, misses, longest;
        logic [K+3:0] expVec, obs1, obs2;
        logic expValid;
        effLen    = (len > DEPTH) ? DEPTH : len;
        lastCycle = effLen * HOLD + 1;
        computeModel(effLen, hits, misses, longest);
        start  = 1'b1;
        length = (AW+1)'(len);
        @(posedge clk); #1;
        start    = 1'b0;
        doneSeen = 0;
        for (int c = 1; c <= lastCycle + 1; c++) begin
            if (disturb && c <= lastCycle) begin
                start        = 1'b1;
                length       = (AW+1)'($urandom);
                load_en      = 1'b1;
                load_addr    = AW'($urandom);
                load_index   = K'($urandom);
                load_outcome = 1'($urandom);
            end else begin
                start   = 1'b0;
                load_en = 1'b0;
            end
            #1;
            expValid = (c <= effLen * HOLD);
            expVec   = '0;
            if (expValid) begin
                entry  = (c - 1) / HOLD;
                expVec = {1'b1, 1'b1, 1'b0, mdlIdx[entry], mdlOut[entry]};
            end else if (c == lastCycle) begin
                expVec = {3'b001, {K{1'b0}}, 1'b0};
            end
            obs1 = {valid, busy, done, index, branch_outcome};
            obs2 = {valid2, busy2, done2, index2, outcome2};
            testsRun++;
            if (obs1 !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL %s cycle %0d {valid,busy,done,index,outcome}: got %b, expected %b", name, c, obs1, expVec);
            end
            testsRun++;
            if (obs2 !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL %s cycle %0d sat-instance presentation: got %b, expected %b", name, c, obs2, expVec);
            end
            if (done === 1'b1) doneSeen++;
            @(posedge clk); #1;
        end
        start   = 1'b0;
        load_en = 1'b0;
        testsRun++;
        if (doneSeen != 1) begin
            testsFailed++;
            $display("[TB] FAIL %s done pulses: got %0d, expected 1", name, doneSeen);
        end
        testsRun++;
        if (hit_count !== CW'(sat(hits, CW)) || miss_count !== CW'(sat(misses, CW)) ||
            max_miss_streak !== CW'(sat(longest, CW))) begin
            testsFailed++;
            $display("[TB] FAIL %s stats hit/miss/max: got %0d/%0d/%0d, expected %0d/%0d/%0d", name,
                     hit_count, miss_count, max_miss_streak, sat(hits, CW), sat(misses, CW), sat(longest, CW));
        end
        testsRun++;
        if (hit2 !== CW2'(sat(hits, CW2)) || miss2 !== CW2'(sat(misses, CW2)) ||
            max2 !== CW2'(sat(longest, CW2))) begin
            testsFailed++;
            $display("[TB] FAIL %s CW=2 stats hit/miss/max: got %0d/%0d/%0d, expected %0d/%0d/%0d", name,
                     hit2, miss2, max2, sat(hits, CW2), sat(misses, CW2), sat(longest, CW2));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_index = '0; load_outcome = 1'b0;
        start = 1'b0; length = '0; predMode = 0; predConst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin mdlIdx[i] = '0; mdlOut[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if ({valid, busy, done, index, branch_outcome, hit_count, miss_count, max_miss_streak} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset outputs: got %b, expected 0",
                     {valid, busy, done, index, branch_outcome, hit_count, miss_count, max_miss_streak});
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if ({valid2, busy2, done2, index2, outcome2, hit2, miss2, max2} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL idle after reset: got %b, expected 0",
                     {valid2, busy2, done2, index2, outcome2, hit2, miss2, max2});
        end
    endtask

    task automatic test_directed();
        loadEntry(0, 4'd1, 1'b1);
        loadEntry(1, 4'd2, 1'b0);
        loadEntry(2, 4'd3, 1'b1);
        loadEntry(3, 4'd4, 1'b1);
        predMode  = 0;
        predConst = 1'b1;
        play_and_score("directed_pred1", 4, 1'b0);
        predConst = 1'b0;
        play_and_score("directed_pred0", 4, 1'b0);
    endtask

    task automatic test_zero_length();
        predMode  = 0;
        predConst = 1'b0;
        play_and_score("zero_length", 0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < DEPTH; a++) loadEntry(a, K'($urandom), 1'($urandom));
            randomizeTable();
            predMode = 2;
            play_and_score("random", 1 + int'($urandom_range(DEPTH - 1)), 1'b0);
        end
    endtask

    task automatic test_long_length();
        randomizeTable();
        predMode = 2;
        play_and_score("length20", 20, 1'b0);
    endtask

    task automatic test_back_to_back_ignore();
        randomizeTable();
        predMode = 2;
        play_and_score("busy_disturbed", DEPTH, 1'b1);
        play_and_score("memory_readback", DEPTH, 1'b0);
    endtask

    task automatic test_reset_mid();
        int doneSeen;
        predMode = 2;
        start  = 1'b1;
        length = (AW+1)'(DEPTH);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        testsRun++;
        if (valid !== 1'b1 || index !== mdlIdx[1]) begin
            testsFailed++;
            $display("[TB] FAIL mid_playback before reset valid/index: got %b/%0d, expected 1/%0d", valid, index, mdlIdx[1]);
        end
        reset = 1'b1;
        #1;
        testsRun++;
        if ({valid, busy, done, index, branch_outcome, hit_count, miss_count, max_miss_streak} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL async reset outputs: got %b, expected 0",
                     {valid, busy, done, index, branch_outcome, hit_count, miss_count, max_miss_streak});
        end
        #2;
        reset    = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || valid === 1'b1) doneSeen++;
        end
        testsRun++;
        if (doneSeen != 0) begin
            testsFailed++;
            $display("[TB] FAIL post-reset activity cycles: got %0d, expected 0", doneSeen);
        end
        play_and_score("after_reset", DEPTH, 1'b0);
    endtask

    task automatic test_saturation();
        for (int a = 0; a < 5; a++) loadEntry(a, K'($urandom), 1'b1);
        predMode  = 0;
        predConst = 1'b0;
        play_and_score("saturation", 5, 1'b0);
        testsRun++;
        if (miss2 !== 2'd3 || max2 !== 2'd3 || hit2 !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL saturation CW=2 miss/max/hit: got %0d/%0d/%0d, expected 3/3/0", miss2, max2, hit2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_length();
        test_random();
        test_long_length();
        test_back_to_back_ignore();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/branch_trace_driver.md
Name: branch_trace_driver

Overview:
Stimulus/scoring end of the predictor interface. Plays a stored branch trace of index and actual-outcome pairs into a predictor, and samples the predictor's prediction for each entry. It tallies hits, misses and the longest misprediction streak. It sits beside the predictor top in the evaluation build and is loaded over a simple write port.

Parameters:
K, 4, branch index width; matches predictor index width
DEPTH, 16, trace memory entries; power of two
AW, 4, trace address width, log2(DEPTH)
HOLD, 2, cycles each entry is held on the outputs; minimum 1
CW, 8, width of statistics counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load_en  in  1  write one trace entry this cycle
load_addr  in  AW  trace entry address
load_index  in  K  branch index to store
load_outcome  in  1  actual outcome to store (1 = taken)
start  in  1  begin playback; level-sampled in IDLE
length  in  AW+1  number of entries to play, starting at address 0
prediction  in  1  predictor's combinational prediction for presented entry
index  out  K  presented branch index
branch_outcome  out  1  presented actual outcome
valid  out  1  an entry is being presented
busy  out  1  playback in progress
done  out  1  one-cycle completion pulse
hit_count  out  CW  entries where prediction == outcome
miss_count  out  CW  entries where prediction != outcome
max_miss_streak  out  CW  longest run of consecutive misses

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0; entry pointer, hold counter and current streak cleared. Trace memory contents are not cleared.
- Trace memory: DEPTH x (K+1) registers, written on a clk edge when load_en=1 and FSM is IDLE. load_en is ignored otherwise.
- FSM states: IDLE, PRESENT, DONE.
- IDLE: on an edge with start=1, clear hit, miss, streak and max counters, and latch eff_len = min(length, DEPTH).
  - eff_len = 0: go to DONE.
  - eff_len > 0: go to PRESENT with pointer 0 and hold counter 0.
- PRESENT: valid=1 and busy=1; index and branch_outcome are driven from memory[pointer], registered and stable for exactly HOLD cycles per entry.
  - Scoring happens at the edge ending the first cycle of each entry (hold counter = 0): prediction is compared with branch_outcome.
  - Hit: hit_count+1; current streak cleared.
  - Miss: miss_count+1; streak+1; max_miss_streak = max(max, streak+1).
  - All counters saturate at 2^CW-1.
  - At the edge ending the HOLD-th cycle: advance the pointer. After pointer = eff_len-1, go to DONE.
- DONE: valid=0, busy=0, done=1 for exactly one cycle, then IDLE. index and branch_outcome return to 0.
- Latency: start accepted at edge 0 → entry i presented in cycles i*HOLD+1 .. (i+1)*HOLD; done high in cycle eff_len*HOLD+1.
- start while busy or in DONE is ignored. Statistics hold their final values in IDLE until the next accepted start.
- Reset mid-playback aborts immediately with no done pulse. Statistics are cleared.

Test Plan:
- Reset, then load entries 0..3 = (idx 1,T), (2,N), (3,T), (4,T); with HOLD=2, start with length=4 and tie prediction=1 → valid high in cycles 1–8, index sequence 1,1,2,2,3,3,4,4; done in cycle 9; hit=3, miss=1, max_miss_streak=1.
- Same trace with prediction=0 → hit=1, miss=3; misses on entries 0, 2 and 3 with entry 1 a hit give max_miss_streak=2.
- start with length=0 → no valid cycles; done pulses in cycle 1; all counters 0. With length=20 → exactly 16 entries played; done in cycle 33.
- Assert start and load_en during playback → no restart, memory unchanged (read back via second playback), single done pulse.
- Assert reset in cycle 4 of playback → all outputs 0 asynchronously, no done pulse; a new start plays from entry 0 with fresh counters.
- CW=2, 5-entry trace of all misses → miss_count saturates at 3, max_miss_streak=3, hit_count=0.
